// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder and its lane aligner.
package dmem_responder_pkg;

    localparam logic [1:0] L8        = 2'b00;
    localparam logic [1:0] L16       = 2'b01;
    localparam logic [1:0] L32       = 2'b10;
    localparam logic [1:0] L_ILLEGAL = 2'b11;

    localparam logic LOAD_SIGNED   = 1'b0;
    localparam logic LOAD_UNSIGNED = 1'b1;

    typedef enum logic [1:0] {
        DS_IDLE,
        DS_WAIT,
        DS_RESP
    } dmem_state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store data/enables toward memory lanes, load data back to bit 0 with extension.
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] word,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_shifted,
    output logic [31:0] load_data,
    output logic        misalign
);

    logic [31:0] word_down;
    logic [15:0] half;

    always_comb begin
        byte_en       = '0;
        wdata_shifted = '0;
        load_data     = '0;
        misalign      = 1'b0;
        word_down     = word >> {addr, 3'b000};
        half          = addr[1] ? word[31:16] : word[15:0];

        case (size)
            L8: begin
                byte_en       = 4'b0001 << addr;
                wdata_shifted = {24'b0, word[7:0]} << {addr, 3'b000};
                load_data     = (is_unsigned == LOAD_UNSIGNED) ? {24'b0, word_down[7:0]}
                                                               : {{24{word_down[7]}}, word_down[7:0]};
            end
            L16: begin
                misalign      = addr[0];
                byte_en       = addr[1] ? 4'b1100 : 4'b0011;
                wdata_shifted = addr[1] ? {word[15:0], 16'b0} : {16'b0, word[15:0]};
                load_data     = (is_unsigned == LOAD_UNSIGNED) ? {16'b0, half}
                                                               : {{16{half[15]}}, half};
            end
            L32: begin
                misalign      = (addr != 2'b00);
                byte_en       = 4'b1111;
                wdata_shifted = word;
                load_data     = word;
            end
            default: begin
                misalign = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding request, fixed wait states, byte-enabled stores, extended loads.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYCLES);
    localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);

    dmem_state_e state, state_next;
    logic [3:0]  wcnt, wcnt_next;
    logic        accept, enter_resp;

    logic        lat_we, lat_unsigned;
    logic [31:0] lat_addr, lat_wdata;
    logic [1:0]  lat_size;

    logic        cur_we, cur_unsigned;
    logic [31:0] cur_addr, cur_wdata;
    logic [1:0]  cur_size;

    logic [31:0]      mem [DEPTH_WORDS];
    logic [IDX_W-1:0] idx;
    logic [31:0]      rd_word, raw_word;

    logic [3:0]  byte_en;
    logic [31:0] wdata_shifted, load_data;
    logic        misalign, fault;

    // With no wait states the commit happens on the accepting edge, so the
    // live request feeds the datapath in IDLE and the latched copy elsewhere.
    always_comb begin
        if (state == DS_IDLE) begin
            cur_we       = req_we_i;
            cur_addr     = req_addr_i;
            cur_size     = req_size_i;
            cur_unsigned = req_unsigned_i;
            cur_wdata    = req_wdata_i;
        end else begin
            cur_we       = lat_we;
            cur_addr     = lat_addr;
            cur_size     = lat_size;
            cur_unsigned = lat_unsigned;
            cur_wdata    = lat_wdata;
        end
    end

    assign idx      = cur_addr[IDX_W+1:2];
    assign rd_word  = mem[idx];
    assign raw_word = cur_we ? cur_wdata : rd_word;

    dmem_lane_align u_align (
        .addr          (cur_addr[1:0]),
        .size          (cur_size),
        .is_unsigned   (cur_unsigned),
        .word          (raw_word),
        .byte_en       (byte_en),
        .wdata_shifted (wdata_shifted),
        .load_data     (load_data),
        .misalign      (misalign)
    );

    assign fault = (cur_size == L_ILLEGAL) || misalign || (cur_addr[31:2] >= DEPTH_LIM);

    always_comb begin
        state_next  = state;
        wcnt_next   = wcnt;
        accept      = 1'b0;
        enter_resp  = 1'b0;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;

        case (state)
            DS_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_next = DS_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = DS_WAIT;
                        wcnt_next  = 4'd1;
                    end
                end
            end
            DS_WAIT: begin
                if (wcnt == WAIT_LAST) begin
                    state_next = DS_RESP;
                    enter_resp = 1'b1;
                    wcnt_next  = '0;
                end else begin
                    wcnt_next = wcnt + 4'd1;
                end
            end
            DS_RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    state_next = DS_IDLE;
                end
            end
            default: begin
                state_next = DS_IDLE;
                wcnt_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= DS_IDLE;
            wcnt        <= '0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            state <= state_next;
            wcnt  <= wcnt_next;
            if (accept) begin
                lat_we       <= req_we_i;
                lat_addr     <= req_addr_i;
                lat_size     <= req_size_i;
                lat_unsigned <= req_unsigned_i;
                lat_wdata    <= req_wdata_i;
            end
            if (enter_resp) begin
                rsp_err_o   <= fault;
                rsp_rdata_o <= (fault || cur_we) ? '0 : load_data;
            end else if (state == DS_RESP && rsp_ready_i) begin
                rsp_err_o   <= 1'b0;
                rsp_rdata_o <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && enter_resp && cur_we && !fault) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[idx][8*b +: 8] <= wdata_shifted[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: byte-array reference model, directed plan steps, then randomized traffic.
module tb_dmem_responder;

    localparam int DEPTH = 1024;

    logic        clk, rst;
    logic        valid_a, valid_b;
    logic        ready_a, ready_b;
    logic        rvalid_a, rvalid_b;
    logic        err_a, err_b;
    logic [31:0] rdata_a, rdata_b;
    logic        req_we, req_uns, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;

    logic        sel;
    logic        o_ready, o_valid, o_err;
    logic [31:0] o_rdata;

    int total = 0;
    int bad   = 0;

    logic [7:0] mb [2][4096];

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(valid_a), .req_ready_o(ready_a),
        .req_we_i(req_we), .req_addr_i(req_addr), .req_size_i(req_size),
        .req_unsigned_i(req_uns), .req_wdata_i(req_wdata),
        .rsp_valid_o(rvalid_a), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rdata_a), .rsp_err_o(err_a)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .rst(rst),
        .req_valid_i(valid_b), .req_ready_o(ready_b),
        .req_we_i(req_we), .req_addr_i(req_addr), .req_size_i(req_size),
        .req_unsigned_i(req_uns), .req_wdata_i(req_wdata),
        .rsp_valid_o(rvalid_b), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rdata_b), .rsp_err_o(err_b)
    );

    assign o_ready = sel ? ready_b  : ready_a;
    assign o_valid = sel ? rvalid_b : rvalid_a;
    assign o_err   = sel ? err_b    : err_a;
    assign o_rdata = sel ? rdata_b  : rdata_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: memory is a flat byte array; a request is n = 2**size bytes starting at addr.
    task automatic model_op(input logic we, input logic [31:0] addr, input logic [1:0] size,
                            input logic uns, input logic [31:0] wd,
                            output logic [31:0] erd, output logic eerr);
        int n;
        longint unsigned v;
        int m;
        m    = sel ? 1 : 0;
        eerr = (size == 2'b11) || (size == 2'b01 && addr % 2 != 0) ||
               (size == 2'b10 && addr % 4 != 0) || (addr >= 32'(4 * DEPTH));
        erd  = '0;
        if (!eerr) begin
            n = 1 << size;
            if (we) begin
                for (int i = 0; i < n; i++) mb[m][int'(addr) + i] = wd[8*i +: 8];
            end else begin
                v = 0;
                for (int i = 0; i < n; i++) v = v | (longint'(mb[m][int'(addr) + i]) << (8 * i));
                if (!uns && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 1);
                erd = v[31:0];
            end
        end
    endtask

    // Entered and left at #1 after a rising edge with the selected DUT idle.
    task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                       input logic [1:0] size, input logic uns, input logic [31:0] wd,
                       input int hold, output logic [31:0] got);
        logic [31:0] erd;
        logic        eerr;
        int          lat;
        model_op(we, addr, size, uns, wd, erd, eerr);
        check({tag, ".ready_in"}, 32'(o_ready), 32'd1);
        req_we = we; req_addr = addr; req_size = size; req_uns = uns; req_wdata = wd;
        if (sel) valid_b = 1'b1; else valid_a = 1'b1;
        @(posedge clk); #1;
        valid_a = 1'b0; valid_b = 1'b0;
        req_we = $urandom; req_addr = $urandom; req_size = 2'($urandom);
        req_uns = $urandom; req_wdata = $urandom;
        lat = 1;
        while (o_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        got = o_rdata;
        check({tag, ".latency"}, 32'(lat), sel ? 32'd1 : 32'd2);
        check({tag, ".rdata"}, o_rdata, erd);
        check({tag, ".err"}, 32'(o_err), 32'(eerr));
        check({tag, ".ready_busy"}, 32'(o_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check({tag, ".hold_valid"}, 32'(o_valid), 32'd1);
            check({tag, ".hold_rdata"}, o_rdata, erd);
            check({tag, ".hold_err"}, 32'(o_err), 32'(eerr));
            check({tag, ".hold_ready"}, 32'(o_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({tag, ".idle_valid"}, 32'(o_valid), 32'd0);
        check({tag, ".idle_ready"}, 32'(o_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] got, erd, rnd_addr;
        logic        eerr;
        logic [1:0]  rnd_size;
        int          r;

        sel = 1'b0; rst = 1'b1; valid_a = 1'b0; valid_b = 1'b0; rsp_ready = 1'b0;
        req_we = 1'b0; req_addr = '0; req_size = '0; req_uns = 1'b0; req_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset.ready",  32'(ready_a),  32'd1);
        check("reset.valid",  32'(rvalid_a), 32'd0);
        check("reset.rdata",  rdata_a,       32'd0);
        check("reset.err",    32'(err_a),    32'd0);
        check("reset.valid0", 32'(rvalid_b), 32'd0);

        for (int w = 0; w < 32; w++) begin
            sel = 1'b0; txn("prefill", 1'b1, 32'(4 * w), 2'b10, 1'b0, $urandom, 0, got);
            sel = 1'b1; txn("prefill0", 1'b1, 32'(4 * w), 2'b10, 1'b0, 32'd0, 0, got);
        end
        sel = 1'b0;

        txn("st32", 1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 0, got);
        check("st32.rdata_zero", got, 32'd0);
        txn("ld32", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 0, got);
        check("ld32.value", got, 32'hDEADBEEF);
        txn("st8", 1'b1, 32'h13, 2'b00, 1'b0, 32'h80, 0, got);
        txn("ld8s", 1'b0, 32'h13, 2'b00, 1'b0, 32'h0, 0, got);
        check("ld8s.value", got, 32'hFFFFFF80);
        txn("ld8u", 1'b0, 32'h13, 2'b00, 1'b1, 32'h0, 0, got);
        check("ld8u.value", got, 32'h00000080);
        txn("ld32b", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 0, got);
        check("ld32b.value", got, 32'h80ADBEEF);

        txn("st16", 1'b1, 32'h22, 2'b01, 1'b0, 32'h8001, 0, got);
        txn("ld16s", 1'b0, 32'h22, 2'b01, 1'b0, 32'h0, 0, got);
        check("ld16s.value", got, 32'hFFFF8001);
        txn("ld16mis", 1'b0, 32'h21, 2'b01, 1'b0, 32'h0, 0, got);
        check("ld16mis.err", 32'(err_a), 32'd0);
        txn("st32mis", 1'b1, 32'h22, 2'b10, 1'b0, 32'h5555AAAA, 0, got);
        txn("reread16", 1'b0, 32'h22, 2'b01, 1'b1, 32'h0, 0, got);
        check("reread16.value", got, 32'h00008001);
        txn("size11", 1'b0, 32'h10, 2'b11, 1'b0, 32'h0, 0, got);
        txn("oob", 1'b0, 32'h1000, 2'b10, 1'b0, 32'h0, 0, got);
        txn("oob_st", 1'b1, 32'h1004, 2'b10, 1'b0, 32'h11111111, 0, got);
        txn("hold5", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 5, got);
        check("hold5.value", got, 32'h80ADBEEF);

        for (int k = 0; k < 60; k++) begin
            r        = $urandom_range(0, 15);
            rnd_addr = 32'($urandom_range(0, 127));
            rnd_size = 2'($urandom_range(0, 2));
            if (r == 0) rnd_size = 2'b11;
            if (r == 1) rnd_addr = 32'h1000 + 32'($urandom_range(0, 255));
            if (r == 2) rnd_addr = 32'hFFFFFFFC;
            txn("rand", 1'($urandom), rnd_addr, rnd_size, 1'($urandom), $urandom,
                $urandom_range(0, 3), got);
        end

        // Reset while waiting: the store must not land.
        txn("zero40", 1'b1, 32'h40, 2'b10, 1'b0, 32'h0, 0, got);
        req_we = 1'b1; req_addr = 32'h40; req_size = 2'b10; req_uns = 1'b0; req_wdata = 32'h12345678;
        valid_a = 1'b1;
        @(posedge clk); #1;
        valid_a = 1'b0;
        check("rstwait.in_wait", 32'(ready_a), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstwait.ready", 32'(ready_a),  32'd1);
        check("rstwait.valid", 32'(rvalid_a), 32'd0);
        check("rstwait.rdata", rdata_a,       32'd0);
        check("rstwait.err",   32'(err_a),    32'd0);
        @(posedge clk); #1;
        check("rstwait.still_idle", 32'(rvalid_a), 32'd0);
        txn("ld40", 1'b0, 32'h40, 2'b10, 1'b0, 32'h0, 0, got);
        check("ld40.value", got, 32'h0);

        // Reset while responding: the committed store persists.
        req_we = 1'b1; req_addr = 32'h44; req_size = 2'b10; req_uns = 1'b0; req_wdata = 32'hCAFEF00D;
        valid_a = 1'b1;
        @(posedge clk); #1;
        valid_a = 1'b0;
        @(posedge clk); #1;
        check("rstresp.valid_before", 32'(rvalid_a), 32'd1);
        model_op(1'b1, 32'h44, 2'b10, 1'b0, 32'hCAFEF00D, erd, eerr);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstresp.valid", 32'(rvalid_a), 32'd0);
        check("rstresp.ready", 32'(ready_a),  32'd1);
        txn("ld44", 1'b0, 32'h44, 2'b10, 1'b0, 32'h0, 0, got);
        check("ld44.value", got, 32'hCAFEF00D);

        // Reset and request together: request dropped.
        req_we = 1'b1; req_addr = 32'h48; req_size = 2'b10; req_wdata = 32'hFFFFFFFF;
        valid_a = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        valid_a = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        check("rstreq.ready", 32'(ready_a), 32'd1);
        @(posedge clk); #1;
        check("rstreq.valid", 32'(rvalid_a), 32'd0);
        txn("ld48", 1'b0, 32'h48, 2'b10, 1'b0, 32'h0, 0, got);

        sel = 1'b1;
        txn("w0.st", 1'b1, 32'h40, 2'b10, 1'b0, 32'h12345678, 0, got);
        txn("w0.ld", 1'b0, 32'h40, 2'b10, 1'b0, 32'h0, 0, got);
        check("w0.ld.value", got, 32'h12345678);
        txn("w0.ld8", 1'b0, 32'h41, 2'b00, 1'b0, 32'h0, 2, got);
        check("w0.ld8.value", got, 32'h00000056);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
